cfu_cmd_master: RTL and testbench
=================================

Name: cfu_cmd_master

Overview:
- Initiator-side engine for the CFU command/response interface.
- Given a job descriptor, it performs the full matmul sequence by issuing CFU commands itself, replacing CPU-driven software loops in system simulation and the DMA-style host path:
  - streams A and B words from a source memory,
  - sets K/M/N,
  - starts the TPU with the input offset,
  - polls busy,
  - reads back every 128-bit C row into a result memory.

Parameters:
- ADDR_BITS, 12, width of buffer index and source/result memory addresses.
- POLL_MAX, 4096, maximum busy polls before the job aborts with timeout.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle job request; ignored while busy=1.
- a_words  in  ADDR_BITS  number of A words to load.
- b_words  in  ADDR_BITS  number of B words to load.
- c_rows  in  ADDR_BITS  number of C rows to read back.
- k_dim  in  8  K argument.
- m_dim  in  8  M argument.
- n_dim  in  8  N argument.
- in_offset  in  32  input offset passed with run.
- src_en  out  1  source memory read enable.
- src_addr  out  ADDR_BITS  source read address.
- src_data  in  32  source data; valid exactly 1 cycle after src_en.
- res_we  out  1  result memory write enable.
- res_addr  out  ADDR_BITS+2  result write address.
- res_data  out  32  result write data.
- cmd_valid  out  1  command valid.
- cmd_ready  in  1  CFU accepts the command.
- cmd_payload_function_id  out  10  function id.
- cmd_payload_inputs_0  out  32  operand 0.
- cmd_payload_inputs_1  out  32  operand 1.
- rsp_valid  in  1  response valid.
- rsp_ready  out  1  master accepts the response.
- rsp_payload_outputs_0  in  32  response data.
- busy  out  1  job in progress.
- done  out  1  one-cycle pulse at job completion.
- timeout  out  1  sticky; set when polling exceeds POLL_MAX; cleared by the next accepted start.

Behaviour:
- Reset: state IDLE. All of the following are 0: busy, done, timeout, cmd_valid, rsp_ready, src_en, res_we, addresses, payloads.
- Start acceptance: start in IDLE latches all descriptor inputs, sets busy=1 and clears timeout.
- Function ids (upper 7 bits, lower 3 = 0):
  - load_A=1, load_B=2, run=4, st_arg=5, poll=6.
  - C lanes 0..3 are read with 3, 7, 8, 9 respectively.
- Transaction rule: at most one command outstanding.
  - cmd_valid and payload are held stable until cmd_valid&&cmd_ready.
  - rsp_ready=1 from the cycle cmd_valid rises until the response handshake.
  - The response may arrive in the same cycle as the command handshake (combinational CFU) or any later cycle.
  - The next command is not raised before the current response is accepted.
- States and transitions:
  - IDLE.
  - A_RD: src_en=1, src_addr=i.
  - A_CMD: load_A with inputs_0=i, inputs_1=src_data (captured into a register the cycle after A_RD). After the response, i++; return to A_RD while i<a_words, else go to B_RD. a_words=0 skips directly to B_RD.
  - B_RD / B_CMD: same pattern. src_addr=a_words+j, inputs_0=j, j counts to b_words.
  - ARG: st_arg with inputs_0={24'b0,K} and inputs_1={16'b0,N,M}.
  - RUN: run with inputs_0=0 and inputs_1=in_offset.
  - POLL: issue poll repeatedly.
    - Response 0 → C_RD.
    - Nonzero → reissue the poll; counter++.
    - Counter reaching POLL_MAX with a nonzero response → timeout=1, go to DONE.
  - C_RD: for row r and lane l=0..3, issue the lane's C read with inputs_0=r.
    - The response is written to the result memory in the same cycle as the response handshake: res_we=1, res_addr={r,l[1:0]}, res_data=rsp_payload_outputs_0.
    - Lane 3 advances r. r==c_rows → DONE. c_rows=0 skips directly to DONE.
  - DONE: done=1 and busy=0 for one cycle, then IDLE.
- Widths: i, j and r are ADDR_BITS wide and wrap naturally. Descriptor counts up to 2^ADDR_BITS-1 are supported.
- Simultaneous events: start coinciding with DONE is ignored. Reset has priority over everything.
- Reset mid-job: the next cycle returns to IDLE with cmd_valid=0, res_we=0, no done pulse, and timeout cleared.

Test Plan:
- Job with a_words=2, b_words=1, c_rows=0; src={A0=0x11223344, A1=0x55667788, B0=0xAABBCCDD}; CFU model always ready, combinational responses, poll returns 0 → exact command sequence: load_A(0,0x11223344), load_A(1,0x55667788), load_B(0,0xAABBCCDD), st_arg, run, poll; then done pulse.
- K=8, M=4, N=16, in_offset=128 → st_arg inputs_0=0x00000008, inputs_1=0x00001004; run inputs_1=0x00000080.
- c_rows=2 with CFU returning the lane id; row1 lane2 returns 0xDEADBEEF → 8 result writes in order; address 6 holds 0xDEADBEEF.
- Backpressure: cmd_ready low for 3 cycles and response delayed 2 cycles after acceptance → payload stable throughout, no second command before the response, same result as the unstalled run.
- POLL_MAX=4, poll always returns 1 → exactly 4 polls, then timeout=1 and done pulse with no C reads; the next start clears timeout.
- Assert reset during B_CMD → cmd_valid=0 the next cycle, busy=0, no done pulse; a fresh start then completes normally.

Source files
------------

// File: rtl/cfu_cmd_master.sv
// Job-level CFU initiator: streams A/B words, sets K/M/N, runs, polls busy and
// reads every C row back into a result memory, one command outstanding at a time.
module cfu_cmd_master #(
   parameter int ADDR_BITS = 12,
   parameter int POLL_MAX  = 4096
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [ADDR_BITS-1:0] a_words,
   input  logic [ADDR_BITS-1:0] b_words,
   input  logic [ADDR_BITS-1:0] c_rows,
   input  logic [7:0]           k_dim,
   input  logic [7:0]           m_dim,
   input  logic [7:0]           n_dim,
   input  logic [31:0]          in_offset,
   output logic                 src_en,
   output logic [ADDR_BITS-1:0] src_addr,
   input  logic [31:0]          src_data,
   output logic                 res_we,
   output logic [ADDR_BITS+1:0] res_addr,
   output logic [31:0]          res_data,
   output logic                 cmd_valid,
   input  logic                 cmd_ready,
   output logic [9:0]           cmd_payload_function_id,
   output logic [31:0]          cmd_payload_inputs_0,
   output logic [31:0]          cmd_payload_inputs_1,
   input  logic                 rsp_valid,
   output logic                 rsp_ready,
   input  logic [31:0]          rsp_payload_outputs_0,
   output logic                 busy,
   output logic                 done,
   output logic                 timeout
);
   // Function ids carry the opcode in the upper 7 bits.
   localparam logic [9:0] FID_LOAD_A = 10'd8;
   localparam logic [9:0] FID_LOAD_B = 10'd16;
   localparam logic [9:0] FID_RUN    = 10'd32;
   localparam logic [9:0] FID_ST_ARG = 10'd40;
   localparam logic [9:0] FID_POLL   = 10'd48;

   typedef enum logic [3:0] {
      S_IDLE, S_A_RD, S_A_CMD, S_B_RD, S_B_CMD, S_ARG, S_RUN, S_POLL, S_C_CMD, S_DONE
   } state_t;

   state_t               state_reg;
   logic [ADDR_BITS-1:0] a_cnt_reg, b_cnt_reg, c_cnt_reg, idx_reg, idx_inc;
   logic [1:0]           lane_reg;
   logic [7:0]           k_reg, m_reg, n_reg;
   logic [31:0]          off_reg, poll_cnt_reg;
   logic                 issued_reg;
   logic                 cmd_acc_reg;
   logic                 cmd_fire, rsp_fire, is_cmd_state;

   function automatic logic [9:0] c_fid(input logic [1:0] lane);
      case (lane)
         2'd0:    return 10'd24;
         2'd1:    return 10'd56;
         2'd2:    return 10'd64;
         default: return 10'd72;
      endcase
   endfunction

   assign idx_inc      = idx_reg + ADDR_BITS'(1);
   assign cmd_fire     = cmd_valid && cmd_ready;
   // A response only counts once its command has been (or is being) accepted.
   assign rsp_fire     = rsp_valid && rsp_ready && (cmd_acc_reg || cmd_fire);
   assign is_cmd_state = state_reg inside {S_A_CMD, S_B_CMD, S_ARG, S_RUN, S_POLL, S_C_CMD};

   assign src_en   = (state_reg == S_A_RD) || (state_reg == S_B_RD);
   assign src_addr = (state_reg == S_A_RD) ? idx_reg :
                     (state_reg == S_B_RD) ? a_cnt_reg + idx_reg : '0;
   assign res_we   = (state_reg == S_C_CMD) && rsp_fire;
   assign res_addr = res_we ? {idx_reg, lane_reg} : '0;
   assign res_data = res_we ? rsp_payload_outputs_0 : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg               <= S_IDLE;
         a_cnt_reg               <= '0;
         b_cnt_reg               <= '0;
         c_cnt_reg               <= '0;
         idx_reg                 <= '0;
         lane_reg                <= '0;
         k_reg                   <= '0;
         m_reg                   <= '0;
         n_reg                   <= '0;
         off_reg                 <= '0;
         poll_cnt_reg            <= '0;
         issued_reg              <= 1'b0;
         cmd_acc_reg             <= 1'b0;
         cmd_valid               <= 1'b0;
         rsp_ready               <= 1'b0;
         cmd_payload_function_id <= '0;
         cmd_payload_inputs_0    <= '0;
         cmd_payload_inputs_1    <= '0;
         busy                    <= 1'b0;
         done                    <= 1'b0;
         timeout                 <= 1'b0;
      end else begin
         if (cmd_fire) begin
            cmd_valid   <= 1'b0;
            cmd_acc_reg <= 1'b1;
         end
         if (rsp_fire) begin
            rsp_ready   <= 1'b0;
            cmd_acc_reg <= 1'b0;
            issued_reg  <= 1'b0;
         end
         // Each command state raises its command once, on its first idle cycle.
         if (is_cmd_state && !issued_reg) begin
            issued_reg <= 1'b1;
            cmd_valid  <= 1'b1;
            rsp_ready  <= 1'b1;
            cmd_payload_inputs_0 <= 32'(idx_reg);
            cmd_payload_inputs_1 <= src_data;
            case (state_reg)
               S_A_CMD: cmd_payload_function_id <= FID_LOAD_A;
               S_B_CMD: cmd_payload_function_id <= FID_LOAD_B;
               S_ARG: begin
                  cmd_payload_function_id <= FID_ST_ARG;
                  cmd_payload_inputs_0    <= {24'b0, k_reg};
                  cmd_payload_inputs_1    <= {16'b0, n_reg, m_reg};
               end
               S_RUN: begin
                  cmd_payload_function_id <= FID_RUN;
                  cmd_payload_inputs_0    <= '0;
                  cmd_payload_inputs_1    <= off_reg;
               end
               S_POLL: begin
                  cmd_payload_function_id <= FID_POLL;
                  cmd_payload_inputs_0    <= '0;
                  cmd_payload_inputs_1    <= '0;
               end
               default: begin
                  cmd_payload_function_id <= c_fid(lane_reg);
                  cmd_payload_inputs_1    <= '0;
               end
            endcase
         end

         case (state_reg)
            S_IDLE: if (start) begin
               a_cnt_reg    <= a_words;
               b_cnt_reg    <= b_words;
               c_cnt_reg    <= c_rows;
               k_reg        <= k_dim;
               m_reg        <= m_dim;
               n_reg        <= n_dim;
               off_reg      <= in_offset;
               idx_reg      <= '0;
               lane_reg     <= '0;
               poll_cnt_reg <= '0;
               busy         <= 1'b1;
               timeout      <= 1'b0;
               if (a_words != '0)      state_reg <= S_A_RD;
               else if (b_words != '0) state_reg <= S_B_RD;
               else                    state_reg <= S_ARG;
            end
            S_A_RD: state_reg <= S_A_CMD;
            S_A_CMD: if (rsp_fire) begin
               if (idx_inc == a_cnt_reg) begin
                  idx_reg   <= '0;
                  state_reg <= (b_cnt_reg != '0) ? S_B_RD : S_ARG;
               end else begin
                  idx_reg   <= idx_inc;
                  state_reg <= S_A_RD;
               end
            end
            S_B_RD: state_reg <= S_B_CMD;
            S_B_CMD: if (rsp_fire) begin
               if (idx_inc == b_cnt_reg) begin
                  idx_reg   <= '0;
                  state_reg <= S_ARG;
               end else begin
                  idx_reg   <= idx_inc;
                  state_reg <= S_B_RD;
               end
            end
            S_ARG: if (rsp_fire) state_reg <= S_RUN;
            S_RUN: if (rsp_fire) state_reg <= S_POLL;
            S_POLL: if (rsp_fire) begin
               if (rsp_payload_outputs_0 == '0) begin
                  idx_reg  <= '0;
                  lane_reg <= '0;
                  if (c_cnt_reg == '0) begin
                     state_reg <= S_DONE;
                     done      <= 1'b1;
                     busy      <= 1'b0;
                  end else begin
                     state_reg <= S_C_CMD;
                  end
               end else if (poll_cnt_reg == POLL_MAX - 1) begin
                  timeout   <= 1'b1;
                  state_reg <= S_DONE;
                  done      <= 1'b1;
                  busy      <= 1'b0;
               end else begin
                  poll_cnt_reg <= poll_cnt_reg + 32'd1;
               end
            end
            S_C_CMD: if (rsp_fire) begin
               lane_reg <= lane_reg + 2'd1;
               if (lane_reg == 2'd3) begin
                  idx_reg <= idx_inc;
                  if (idx_inc == c_cnt_reg) begin
                     state_reg <= S_DONE;
                     done      <= 1'b1;
                     busy      <= 1'b0;
                  end
               end
            end
            S_DONE: begin
               done      <= 1'b0;
               state_reg <= S_IDLE;
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_cfu_cmd_master.sv
// Randomized bench for cfu_cmd_master: a job-level model predicts the command
// and result-write sequences; a CFU model supplies randomized handshakes.
module tb_cfu_cmd_master;
   localparam int AB = 8;
   localparam int PM = 4;

   logic          clk = 1'b0;
   logic          reset, start;
   logic [AB-1:0] a_words, b_words, c_rows, src_addr;
   logic [7:0]    k_dim, m_dim, n_dim;
   logic [31:0]   in_offset, src_data, res_data, in0, in1, rsp_payload_outputs_0;
   logic          src_en, res_we, cmd_valid, cmd_ready, rsp_valid, rsp_ready;
   logic          busy, done, timeout;
   logic [AB+1:0] res_addr;
   logic [9:0]    fid;

   always #5 clk = ~clk;

   cfu_cmd_master #(.ADDR_BITS(AB), .POLL_MAX(PM)) dut (
      .clk(clk), .reset(reset), .start(start),
      .a_words(a_words), .b_words(b_words), .c_rows(c_rows),
      .k_dim(k_dim), .m_dim(m_dim), .n_dim(n_dim), .in_offset(in_offset),
      .src_en(src_en), .src_addr(src_addr), .src_data(src_data),
      .res_we(res_we), .res_addr(res_addr), .res_data(res_data),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_payload_function_id(fid), .cmd_payload_inputs_0(in0), .cmd_payload_inputs_1(in1),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_payload_outputs_0(rsp_payload_outputs_0),
      .busy(busy), .done(done), .timeout(timeout)
   );

   typedef struct { logic [9:0] fid; logic [31:0] in0; logic [31:0] in1; logic ck0; logic ck1; } cmd_t;
   typedef struct { logic [AB+1:0] addr; logic [31:0] data; } wr_t;

   cmd_t exp_cmd[$], cmd_log[$];
   wr_t  exp_wr[$], wr_log[$], ref_wr[$];
   logic [31:0] src_mem [0:255];
   int   total = 0, bad = 0;
   int   stall_mode = 0, poll_busy = 0, low_cnt = 0, pend_dly = 0;
   bit   pend = 0, outstanding = 0, prev_hold = 0, prev_cv = 0, last_en = 0;
   bit   job_active = 0, job_done = 0, exp_tmo = 0, start_pend = 0, reset_pend = 1, junk_en = 0;
   logic [31:0] pend_data, pin0, pin1;
   logic [9:0]  pfid;
   logic [AB-1:0] last_addr;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got=%h want=%h", name, act, want);
      end
   endtask

   task automatic fail_now(input string name);
      total++;
      bad++;
      $display("FAIL %s", name);
   endtask

   function automatic logic [31:0] c_val(input logic [31:0] r, input int l);
      if (r == 1 && l == 2) return 32'hDEADBEEF;
      return (r << 16) | 32'(l);
   endfunction

   function automatic logic [9:0] c_fid(input int l);
      case (l)
         0: return 10'd24;
         1: return 10'd56;
         2: return 10'd64;
         default: return 10'd72;
      endcase
   endfunction

   function automatic int lane_of(input logic [9:0] f);
      for (int l = 0; l < 4; l++) if (c_fid(l) == f) return l;
      return -1;
   endfunction

   // One clock: drive every input at the falling edge, then observe and check.
   task automatic cycle();
      logic [31:0] d;
      cmd_t c, e;
      wr_t  w, ew;
      @(negedge clk);
      reset      = reset_pend;
      start      = start_pend | (junk_en && busy && ($urandom_range(0, 7) == 0));
      start_pend = 0;
      src_data   = last_en ? src_mem[last_addr] : $urandom;
      last_en    = src_en;
      last_addr  = src_addr;
      rsp_valid  = 1'b0;
      rsp_payload_outputs_0 = $urandom;
      if (pend) begin
         cmd_ready = 1'($urandom_range(0, 1));
         if (pend_dly == 0) begin
            rsp_valid = 1'b1;
            rsp_payload_outputs_0 = pend_data;
         end else pend_dly--;
      end else begin
         case (stall_mode)
            0: cmd_ready = 1'b1;
            1: cmd_ready = ($urandom_range(0, 2) != 0);
            default: begin
               cmd_ready = (low_cnt >= 3);
               if (cmd_valid && low_cnt < 3) low_cnt++;
            end
         endcase
         if (cmd_valid && cmd_ready) begin
            low_cnt = 0;
            d = $urandom;
            if (fid == 10'd48) begin
               if (poll_busy > 0) begin
                  d = $urandom | 32'd1;
                  poll_busy--;
               end else d = 32'd0;
            end else if (lane_of(fid) >= 0) d = c_val(in0, lane_of(fid));
            pend      = 1;
            pend_data = d;
            pend_dly  = (stall_mode == 0) ? 0 : (stall_mode == 1) ? $urandom_range(0, 2) : 2;
            if (pend_dly == 0) begin
               rsp_valid = 1'b1;
               rsp_payload_outputs_0 = d;
            end else pend_dly--;
         end
      end
      #1;
      if (reset) begin
         prev_hold = 0;
         prev_cv   = 0;
         return;
      end
      if (prev_hold) begin
         chk("hold_valid", 32'(cmd_valid), 32'd1);
         chk("hold_fid", 32'(fid), 32'(pfid));
         chk("hold_in0", in0, pin0);
         chk("hold_in1", in1, pin1);
      end
      if (cmd_valid && !prev_cv) begin
         chk("one_outstanding", 32'(outstanding), 32'd0);
         chk("rsp_ready_rise", 32'(rsp_ready), 32'd1);
      end
      if (cmd_valid && cmd_ready) begin
         c = '{fid, in0, in1, 1'b1, 1'b1};
         cmd_log.push_back(c);
         if (exp_cmd.size() == 0) fail_now("unexpected_cmd");
         else begin
            e = exp_cmd.pop_front();
            chk("cmd_fid", 32'(fid), 32'(e.fid));
            if (e.ck0) chk("cmd_in0", in0, e.in0);
            if (e.ck1) chk("cmd_in1", in1, e.in1);
         end
         outstanding = 1;
      end
      if (rsp_valid && rsp_ready && pend) begin
         outstanding = 0;
         pend        = 0;
      end
      if (res_we) begin
         w = '{res_addr, res_data};
         wr_log.push_back(w);
         if (exp_wr.size() == 0) fail_now("unexpected_write");
         else begin
            ew = exp_wr.pop_front();
            chk("wr_addr", 32'(res_addr), 32'(ew.addr));
            chk("wr_data", res_data, ew.data);
         end
      end
      if (done) begin
         if (!job_active) fail_now("spurious_done");
         else begin
            chk("done_cmds_left", 32'(exp_cmd.size()), 32'd0);
            chk("done_wr_left", 32'(exp_wr.size()), 32'd0);
            chk("done_timeout", 32'(timeout), 32'(exp_tmo));
            chk("done_busy", 32'(busy), 32'd0);
            job_done   = 1;
            job_active = 0;
         end
      end
      prev_hold = cmd_valid && !cmd_ready;
      prev_cv   = cmd_valid;
      pfid = fid;
      pin0 = in0;
      pin1 = in1;
   endtask

   task automatic start_job(input int a, input int b, input int c, input logic [7:0] k,
                            input logic [7:0] m, input logic [7:0] n, input logic [31:0] off,
                            input int bp, input int sm);
      int np;
      exp_cmd.delete(); exp_wr.delete(); cmd_log.delete(); wr_log.delete();
      for (int i = 0; i < a; i++) exp_cmd.push_back('{10'd8, 32'(i), src_mem[i], 1'b1, 1'b1});
      for (int j = 0; j < b; j++) exp_cmd.push_back('{10'd16, 32'(j), src_mem[(a + j) % 256], 1'b1, 1'b1});
      exp_cmd.push_back('{10'd40, {24'b0, k}, {16'b0, n, m}, 1'b1, 1'b1});
      exp_cmd.push_back('{10'd32, 32'd0, off, 1'b1, 1'b1});
      exp_tmo = (bp >= PM);
      np = exp_tmo ? PM : bp + 1;
      for (int p = 0; p < np; p++) exp_cmd.push_back('{10'd48, 32'd0, 32'd0, 1'b0, 1'b0});
      if (!exp_tmo)
         for (int r = 0; r < c; r++)
            for (int l = 0; l < 4; l++) begin
               exp_cmd.push_back('{c_fid(l), 32'(r), 32'd0, 1'b1, 1'b0});
               exp_wr.push_back('{(AB+2)'(r * 4 + l), c_val(32'(r), l)});
            end
      poll_busy  = bp;
      stall_mode = sm;
      a_words = AB'(a); b_words = AB'(b); c_rows = AB'(c);
      k_dim = k; m_dim = m; n_dim = n; in_offset = off;
      start_pend = 1;
      job_active = 1;
      job_done   = 0;
      cycle();
      cycle();
      chk("start_busy", 32'(busy), 32'd1);
      chk("start_clears_timeout", 32'(timeout), 32'd0);
      // Descriptor must have been latched; scramble the live inputs.
      a_words = AB'($urandom); b_words = AB'($urandom); c_rows = AB'($urandom);
      k_dim = 8'($urandom); m_dim = 8'($urandom); n_dim = 8'($urandom); in_offset = $urandom;
   endtask

   task automatic wait_job();
      for (int t = 0; t < 5000 && !job_done; t++) cycle();
      if (!job_done) begin
         fail_now("job_no_done");
         job_active = 0;
      end
      cycle();
      cycle();
   endtask

   task automatic run_job(input int a, input int b, input int c, input logic [7:0] k,
                          input logic [7:0] m, input logic [7:0] n, input logic [31:0] off,
                          input int bp, input int sm);
      start_job(a, b, c, k, m, n, off, bp, sm);
      wait_job();
   endtask

   initial begin
      int polls;
      bit seen;
      start = 0; a_words = 0; b_words = 0; c_rows = 0;
      k_dim = 0; m_dim = 0; n_dim = 0; in_offset = 0;
      src_data = 0; cmd_ready = 0; rsp_valid = 0; rsp_payload_outputs_0 = 0;
      reset = 1;
      for (int i = 0; i < 256; i++) src_mem[i] = $urandom;
      src_mem[0] = 32'h11223344;
      src_mem[1] = 32'h55667788;
      src_mem[2] = 32'hAABBCCDD;
      cycle(); cycle();
      reset_pend = 0;
      cycle();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_timeout", 32'(timeout), 32'd0);
      chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
      chk("rst_rsp_ready", 32'(rsp_ready), 32'd0);
      chk("rst_src_en", 32'(src_en), 32'd0);
      chk("rst_res_we", 32'(res_we), 32'd0);
      chk("rst_src_addr", 32'(src_addr), 32'd0);
      chk("rst_res_addr", 32'(res_addr), 32'd0);
      chk("rst_fid", 32'(fid), 32'd0);
      chk("rst_in0", in0, 32'd0);
      chk("rst_in1", in1, 32'd0);

      run_job(2, 1, 0, 8'd1, 8'd1, 8'd1, 32'd0, 0, 0);
      $display("job basic: cmds=%0d", cmd_log.size());
      chk("j1_ncmd", 32'(cmd_log.size()), 32'd6);
      if (cmd_log.size() == 6) begin
         chk("j1_c0_fid", 32'(cmd_log[0].fid), 32'd8);
         chk("j1_c0_in1", cmd_log[0].in1, 32'h11223344);
         chk("j1_c1_in0", cmd_log[1].in0, 32'd1);
         chk("j1_c1_in1", cmd_log[1].in1, 32'h55667788);
         chk("j1_c2_fid", 32'(cmd_log[2].fid), 32'd16);
         chk("j1_c2_in1", cmd_log[2].in1, 32'hAABBCCDD);
         chk("j1_c5_fid", 32'(cmd_log[5].fid), 32'd48);
      end

      run_job(0, 0, 2, 8'd8, 8'd4, 8'd16, 32'd128, 0, 0);
      $display("job args: cmds=%0d writes=%0d", cmd_log.size(), wr_log.size());
      chk("j2_arg_in0", cmd_log[0].in0, 32'h00000008);
      chk("j2_arg_in1", cmd_log[0].in1, 32'h00001004);
      chk("j2_run_in1", cmd_log[1].in1, 32'h00000080);
      chk("j2_nwr", 32'(wr_log.size()), 32'd8);
      if (wr_log.size() == 8) begin
         chk("j2_wr6_addr", 32'(wr_log[6].addr), 32'd6);
         chk("j2_wr6_data", wr_log[6].data, 32'hDEADBEEF);
         chk("j2_wr1_data", wr_log[1].data, 32'd1);
      end
      ref_wr = wr_log;

      run_job(0, 0, 2, 8'd8, 8'd4, 8'd16, 32'd128, 1, 2);
      $display("job backpressure: writes=%0d", wr_log.size());
      chk("bp_nwr", 32'(wr_log.size()), 32'(ref_wr.size()));
      for (int i = 0; i < wr_log.size() && i < ref_wr.size(); i++)
         chk("bp_same_data", wr_log[i].data, ref_wr[i].data);

      run_job(1, 1, 2, 8'd3, 8'd3, 8'd3, 32'd5, 100, 1);
      polls = 0;
      foreach (cmd_log[i]) if (cmd_log[i].fid == 10'd48) polls++;
      $display("job timeout: polls=%0d", polls);
      chk("tmo_polls", 32'(polls), 32'd4);
      chk("tmo_nwr", 32'(wr_log.size()), 32'd0);
      chk("tmo_sticky", 32'(timeout), 32'd1);

      start_job(2, 3, 1, 8'd2, 8'd2, 8'd2, 32'd9, 0, 1);
      seen = 0;
      for (int t = 0; t < 300 && !seen; t++) begin
         cycle();
         seen = cmd_valid && (fid == 10'd16);
      end
      if (!seen) fail_now("rst_mid_no_b_cmd");
      reset_pend = 1;
      cycle();
      reset_pend = 0;
      job_active = 0;
      pend = 0;
      outstanding = 0;
      last_en = 0;
      cycle();
      $display("job reset mid-run");
      chk("rmid_cmd_valid", 32'(cmd_valid), 32'd0);
      chk("rmid_busy", 32'(busy), 32'd0);
      chk("rmid_done", 32'(done), 32'd0);
      chk("rmid_timeout", 32'(timeout), 32'd0);
      chk("rmid_res_we", 32'(res_we), 32'd0);
      repeat (10) cycle();
      run_job(2, 3, 1, 8'd2, 8'd2, 8'd2, 32'd9, 0, 1);
      $display("job after reset: cmds=%0d", cmd_log.size());

      junk_en = 1;
      for (int n = 0; n < 30; n++) begin
         run_job($urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 3),
                 8'($urandom), 8'($urandom), 8'($urandom), $urandom,
                 $urandom_range(0, 5), $urandom_range(0, 2));
         $display("job random %0d: cmds=%0d writes=%0d timeout=%0d", n, cmd_log.size(), wr_log.size(), timeout);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
